// File: rtl/rr_ack_arbiter.sv
// rr_ack_arbiter: round-robin arbiter for one shared resource.
// The arbiter grants one requester at a time. It then waits for a completion
// ack from the resource. If no ack arrives within ACK_WIN edges, it releases
// the grant and flags a timeout.
//
// Handshake: req[i] is a level request. A grant is a registered one-hot on gnt
// that stays stable until released; changes to req (including the grantee
// dropping its own request) never release it. The grant is released by an ack
// sampled at WAIT edge k, 1 <= k <= ACK_WIN, or by the ACK_WIN-edge timeout.
// Edge 0 is the first edge that samples gnt high. An ack at edge 0, or any ack
// seen while idle, is ignored. done and timeout are one-cycle pulses that
// appear in the cycle after the releasing edge.
module rr_ack_arbiter #(
   parameter int N       = 4,
   parameter int ACK_WIN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 ack,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [$clog2(N)-1:0] to_id,
   output logic [7:0]           timeout_cnt,
   output logic                 dbg_state_o,
   output logic [$clog2(N)-1:0] dbg_ptr_o
);

   localparam int IDW = $clog2(N);
   localparam int CW  = $clog2(ACK_WIN + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;
   logic           timeout_q, timeout_d;
   logic [IDW-1:0] to_id_q, to_id_d;
   logic [7:0]     tcnt_q, tcnt_d;

   // Arbitration result: first requester at or after ptr, wrapping modulo N.
   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   int             cand;
   logic [IDW-1:0] cand_idx;

   // Index of the requester after the current grantee, wrapping modulo N.
   logic [IDW-1:0] next_ptr;

   // Round-robin search over the request vector starting at ptr.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 0; i < N; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDW'(cand);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Rotate priority to the requester after whoever was just served.
   always_comb begin
      next_ptr = '0;
      if (gnt_id_q != IDW'(N - 1)) begin
         next_ptr = gnt_id_q + 1'b1;
      end
   end

   // Next-state and output logic for the IDLE/WAIT controller.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      to_id_d   = to_id_q;
      tcnt_d    = tcnt_q;

      unique case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (pick_found) begin
               gnt_d[pick_idx] = 1'b1;
               gnt_id_d        = pick_idx;
               cnt_d           = '0;
               state_d         = S_WAIT;
            end
         end

         S_WAIT: begin
            if (ack && (cnt_q != '0)) begin
               // Accepted ack. An ack at the last window edge also lands here,
               // so it wins over the timeout.
               gnt_d   = '0;
               done_d  = 1'b1;
               ptr_d   = next_ptr;
               state_d = S_IDLE;
            end else if (cnt_q == CW'(ACK_WIN)) begin
               gnt_d     = '0;
               timeout_d = 1'b1;
               to_id_d   = gnt_id_q;
               if (tcnt_q != 8'hFF) begin
                  tcnt_d = tcnt_q + 8'd1;
               end
               ptr_d   = next_ptr;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         to_id_q   <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         to_id_q   <= to_id_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_id      = gnt_id_q;
   assign busy        = (state_q == S_WAIT);
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign to_id       = to_id_q;
   assign timeout_cnt = tcnt_q;
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

   // Structural invariants of the grant and completion outputs.
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
   a_pulse_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(done_q && timeout_q));
   a_busy_gnt:    assert property (@(posedge clk) disable iff (!rst_n) (busy == (gnt_q != '0)));

endmodule

// File: tb/tb_rr_ack_arbiter.sv
// Directed bench for rr_ack_arbiter (N=4, ACK_WIN=4).
module tb_rr_ack_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [1:0] to_id;
  logic [7:0] timeout_cnt;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       to;
    logic [1:0] gid;
    logic [1:0] toid;
    logic [7:0] tcnt;
  } vec_t;

  vec_t vq[$];

  rr_ack_arbiter #(.N(4), .ACK_WIN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .to_id       (to_id),
    .timeout_cnt (timeout_cnt),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic a,
                     input logic [3:0] g, input logic b, input logic d, input logic t,
                     input logic [1:0] gi, input logic [1:0] ti, input logic [7:0] tc);
    vec_t v;
    v.rst_n = r;  v.req = rq; v.ack = a;
    v.gnt = g;    v.busy = b; v.done = d; v.to = t;
    v.gid = gi;   v.toid = ti; v.tcnt = tc;
    vq.push_back(v);
  endtask

  initial begin
    int n_to;
    int guard;
    logic [7:0] exp_tcnt;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;

    // Each row: inputs applied before an edge, outputs expected after it.
    // Reset held with everything asserted
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    // req=0101, ack at edge 2 of each grant
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 1, 4'b0000, 0, 1, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0100, 1, 0, 0, 2, 0, 0);
    add(1, 4'b0101, 0, 4'b0100, 1, 0, 0, 2, 0, 0);
    add(1, 4'b0101, 0, 4'b0100, 1, 0, 0, 2, 0, 0);
    add(1, 4'b0101, 1, 4'b0000, 0, 1, 0, 2, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 1, 4'b0000, 0, 1, 0, 0, 0, 0);
    // req=0001, ack only at edge 0 -> timeout at edge 4
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 1, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 4'b0000, 0, 0, 1, 0, 0, 1);
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 1);
    add(1, 4'b0001, 0, 4'b0001, 1, 0, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 0, 0, 1);
    // ack exactly at edge 4, then a stray ack in IDLE
    add(1, 4'b0010, 0, 4'b0010, 1, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 1, 0, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 0, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0, 1);
    // grant 2 completes, then 1111 -> 1000 (req[3] dropped in WAIT), then wrap to 0001
    add(1, 4'b0100, 0, 4'b0100, 1, 0, 0, 2, 0, 1);
    add(1, 4'b1111, 0, 4'b0100, 1, 0, 0, 2, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 1, 0, 2, 0, 1);
    add(1, 4'b1111, 0, 4'b1000, 1, 0, 0, 3, 0, 1);
    add(1, 4'b0111, 0, 4'b1000, 1, 0, 0, 3, 0, 1);
    add(1, 4'b0111, 0, 4'b1000, 1, 0, 0, 3, 0, 1);
    add(1, 4'b0111, 0, 4'b1000, 1, 0, 0, 3, 0, 1);
    add(1, 4'b0111, 1, 4'b0000, 0, 1, 0, 3, 0, 1);
    add(1, 4'b1111, 0, 4'b0001, 1, 0, 0, 0, 0, 1);
    add(1, 4'b1111, 0, 4'b0001, 1, 0, 0, 0, 0, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n;
      req   = vq[i].req;
      ack   = vq[i].ack;
      step();
      chk($sformatf("row%0d gnt", i),     32'(gnt),         32'(vq[i].gnt));
      chk($sformatf("row%0d busy", i),    32'(busy),        32'(vq[i].busy));
      chk($sformatf("row%0d done", i),    32'(done),        32'(vq[i].done));
      chk($sformatf("row%0d timeout", i), 32'(timeout),     32'(vq[i].to));
      chk($sformatf("row%0d gnt_id", i),  32'(gnt_id),      32'(vq[i].gid));
      chk($sformatf("row%0d to_id", i),   32'(to_id),       32'(vq[i].toid));
      chk($sformatf("row%0d tcnt", i),    32'(timeout_cnt), 32'(vq[i].tcnt));
    end

    // 300 consecutive timeouts on requester 0; the count saturates at 255.
    exp_tcnt = 8'd1;
    n_to     = 0;
    guard    = 0;
    req      = 4'b0001;
    ack      = 1'b0;
    while (n_to < 300 && guard < 2000) begin
      step();
      guard++;
      if (timeout) begin
        n_to++;
        if (exp_tcnt != 8'hFF) exp_tcnt = exp_tcnt + 8'd1;
        chk($sformatf("sat tcnt #%0d", n_to), 32'(timeout_cnt), 32'(exp_tcnt));
        chk($sformatf("sat to_id #%0d", n_to), 32'(to_id), 32'd0);
        chk($sformatf("sat excl #%0d", n_to), 32'(done), 32'd0);
      end
    end
    chk("sat count reached", 32'(n_to), 32'd300);
    chk("sat final tcnt", 32'(timeout_cnt), 32'd255);

    // Reset during WAIT: grant drops at the reset edge, no pulse, ptr back to 0.
    guard = 0;
    while (!busy && guard < 10) begin
      step();
      guard++;
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    chk("rst tcnt", 32'(timeout_cnt), 32'd0);
    chk("rst ptr", 32'(dbg_ptr), 32'd0);
    chk("rst gnt_id", 32'(gnt_id), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);

    // First edge out of reset arbitrates from ptr=0: 1001 -> 0001.
    rst_n = 1'b1;
    req   = 4'b1001;
    step();
    chk("post-rst gnt", 32'(gnt), 32'b0001);
    chk("post-rst busy", 32'(busy), 32'd1);
    chk("post-rst done", 32'(done), 32'd0);
    chk("post-rst timeout", 32'(timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
